decode_issue: RTL

- Decode/issue stage directly upstream of the register file.
- Accepts 32-bit instructions from fetch (valid/ready), decodes them, and drives the regfile read addresses from a held instruction register.
- Stalls on RAW hazards using a 32-entry pending-write scoreboard that snoops writeback.
- Presents decoded control to execute, aligned with the regfile's registered r1_value/r2_value.

---
 rtl/decode_issue_pkg.sv | 68 ++++++
 rtl/decode_issue_scoreboard.sv | 42 ++++
 rtl/decode_issue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: opcodes, instruction field
// positions, FSM encoding and the per-opcode source/destination classifier.
package decode_issue_pkg;

   localparam int NREG_DEF   = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int RIDX_W     = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_IALU  = 6'h08;
   localparam logic [5:0] OP_LOAD  = 6'h23;
   localparam logic [5:0] OP_STORE = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 26;
   localparam int RS1_HI   = 25;
   localparam int RS1_LO   = 21;
   localparam int RS2_HI   = 20;
   localparam int RS2_LO   = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_READY = 2'd2
   } state_t;

   typedef struct packed {
      logic              use_rs1;
      logic              use_rs2;
      logic              writes;
      logic [RIDX_W-1:0] dest;
      logic              illegal;
   } dec_t;

   // Unknown opcodes read nothing and write nothing, so they never stall.
   function automatic dec_t decode_class(input logic [31:0] instr);
      dec_t d;
      d = '0;
      case (instr[OPC_HI:OPC_LO])
         OP_RTYPE: begin
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
            d.writes  = 1'b1;
            d.dest    = instr[RD_HI:RD_LO];
         end
         OP_IALU, OP_LOAD: begin
            d.use_rs1 = 1'b1;
            d.writes  = 1'b1;
            d.dest    = instr[RS2_HI:RS2_LO];
         end
         OP_STORE, OP_BEQ: begin
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue of a writer,
// cleared by writeback; a same-cycle set and clear of one bit leaves it set.
module decode_issue_scoreboard
   import decode_issue_pkg::*;
#(
   parameter int NREG  = NREG_DEF,
   parameter int IDX_W = RIDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] look1_idx,
   input  logic [IDX_W-1:0] look2_idx,
   output logic             look1_pending,
   output logic             look2_pending,
   output logic [NREG-1:0]  pending
);

   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] pending_next;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
      pending_next = (pending & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= pending_next;
   end

   assign look1_pending = pending[look1_idx];
   assign look2_pending = pending[look2_idx];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: holds one instruction, stalls on RAW hazards against
// the pending-write scoreboard, and drives the regfile read addresses from IR.
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; valid never depends on ready, and payload is stable while valid waits.
module decode_issue
   import decode_issue_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_instr,
   output logic              in_ready,
   input  logic              flush,
   input  logic              wb_write_enable,
   input  logic [4:0]        wb_write_add,
   output logic [ADDR_W-1:0] r1_add,
   output logic [ADDR_W-1:0] r2_add,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_opcode,
   output logic [5:0]        out_funct,
   output logic [4:0]        out_rd,
   output logic              out_writes,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_illegal,
   output state_t            dbg_state,
   output logic [NREG-1:0]   dbg_pending
);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] ir;
   logic              ir_load;
   logic              issue;
   logic              stall;
   logic              rs1_pending;
   logic              rs2_pending;
   dec_t              dec;

   assign dec   = decode_class(ir[31:0]);
   assign stall = (dec.use_rs1 & rs1_pending) | (dec.use_rs2 & rs2_pending);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      ir_load    = 1'b0;
      issue      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ir_load    = 1'b1;
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!stall) state_next = ST_READY;
         end
         ST_READY: begin
            out_valid = 1'b1;
            if (out_ready) begin
               issue    = 1'b1;
               in_ready = 1'b1;
               if (in_valid) begin
                  ir_load    = 1'b1;
                  state_next = ST_CHECK;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // A taken branch kills the held instruction and blocks any same-cycle handshake.
      if (flush) begin
         state_next = ST_IDLE;
         in_ready   = 1'b0;
         ir_load    = 1'b0;
         issue      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       ir <= '0;
      else if (ir_load) ir <= in_instr;
   end

   decode_issue_scoreboard #(
      .NREG  (NREG),
      .IDX_W (RIDX_W)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .set_en        (issue & dec.writes),
      .set_idx       (dec.dest),
      .clr_en        (wb_write_enable),
      .clr_idx       (wb_write_add),
      .look1_idx     (ir[RS1_HI:RS1_LO]),
      .look2_idx     (ir[RS2_HI:RS2_LO]),
      .look1_pending (rs1_pending),
      .look2_pending (rs2_pending),
      .pending       (dbg_pending)
   );

   // IR only changes on accept, so the regfile re-reads the same registers each edge.
   assign r1_add = {{(ADDR_W-RIDX_W){1'b0}}, ir[RS1_HI:RS1_LO]};
   assign r2_add = {{(ADDR_W-RIDX_W){1'b0}}, ir[RS2_HI:RS2_LO]};

   assign out_opcode  = ir[OPC_HI:OPC_LO];
   assign out_funct   = ir[FUNCT_HI:FUNCT_LO];
   assign out_rd      = dec.dest;
   assign out_writes  = dec.writes & out_valid;
   assign out_imm     = {{(DATA_W-16){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
   assign out_illegal = dec.illegal;
   assign dbg_state   = state;

endmodule
